// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops FIFO bytes, packs BYTES lanes per word onto a valid/ready stream, flush closes partial words.
// Optional FIFO_WORD_PACKER_BYTECNT_EN adds a 16-bit transferred-byte counter output.
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                    read_clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [DATA_W-1:0]       fifo_out,
  output logic                    fifo_read_en,
  input  logic                    flush,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W*BYTES-1:0] m_data,
  output logic [BYTES-1:0]        m_keep,
`ifdef FIFO_WORD_PACKER_BYTECNT_EN
  output logic [15:0]             byte_count,
`endif
  output logic                    m_last
);
  localparam int CW = $clog2(BYTES + 1);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int WW = DATA_W * BYTES + BYTES + 1;
  logic [RD_LAT-1:0] pipe;
  logic [CW-1:0] landed, lanes_now;
  logic [IW-1:0] infl, infl_rem;
  logic [DATA_W*BYTES-1:0] acc, acc_n;
  logic [BYTES-1:0] keep;
  logic [1:0] ob_cnt;
  logic [WW-1:0] head, skid, push_word;
  logic flush_pend, flush_req, land, xfer, accept, full, fl_done, do_push, pop;
  int occ;
  assign m_valid = ob_cnt != 2'd0;
  assign {m_last, m_keep, m_data} = head;
  assign fifo_read_en = pop;
  // occ counts every byte owned by the block, buffered words as full words, so
  // capping it at three words keeps both the skid buffer and accumulator from overflowing.
  always_comb begin
    land = pipe[RD_LAT-1];
    xfer = m_valid & m_ready;
    flush_req = flush | flush_pend;
    lanes_now = landed + CW'(land);
    infl_rem = infl - IW'(land);
    full = lanes_now == CW'(BYTES);
    accept = ob_cnt != 2'd2 || xfer;
    fl_done = flush_req && infl_rem == '0;
    do_push = accept && (full || (fl_done && lanes_now != '0));
    acc_n = acc;
    if (land) acc_n[int'(landed)*DATA_W +: DATA_W] = fifo_out;
    keep = '0;
    for (int i = 0; i < BYTES; i++) keep[i] = i < int'(lanes_now);
    push_word = {fl_done, keep, acc_n};
    occ = BYTES * int'(ob_cnt) + int'(landed) + int'(infl) - (xfer ? BYTES : 0);
    pop = reset && !fifo_empty && !flush_req && occ < 3 * BYTES;
  end
  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
      infl <= '0;
      landed <= '0;
      acc <= '0;
      flush_pend <= 1'b0;
      ob_cnt <= 2'd0;
      head <= '0;
      skid <= '0;
    end else begin
      pipe <= RD_LAT'({pipe, pop});
      infl <= infl_rem + IW'(pop);
      landed <= do_push ? '0 : lanes_now;
      acc <= do_push ? '0 : acc_n;
      flush_pend <= flush_req && !(fl_done && (lanes_now == '0 || do_push));
      ob_cnt <= ob_cnt + 2'(do_push) - 2'(xfer);
      if ((do_push && (ob_cnt == 2'd0 || (xfer && ob_cnt == 2'd1))) || (xfer && ob_cnt == 2'd2))
        head <= (ob_cnt == 2'd2) ? skid : push_word;
      if (do_push && ((ob_cnt == 2'd1 && !xfer) || (ob_cnt == 2'd2 && xfer)))
        skid <= push_word;
    end
  end
`ifdef FIFO_WORD_PACKER_BYTECNT_EN
  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) byte_count <= '0;
    else if (xfer) byte_count <= byte_count + 16'($countones(m_keep));
  end
`endif
endmodule
